// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches over req/gnt/rvalid,
// and queues {instr, pc} toward decode; execute-stage redirects flush the queue and restart fetch.
module core_fetch_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i,
  output logic                  flush_o,
  output logic                  misalign_o
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  discard_q, discard_d;
  logic                  flush_q, flush_d;
  logic                  misalign_q, misalign_d;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d, count_nxt;
  logic [DATA_WIDTH-1:0] instr_mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q [BUF_DEPTH];
  logic                  push, pop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    push      = (state_q == StWait) && imem_rvalid_i && !discard_q;
    pop       = instr_valid_o && instr_ready_i;
    count_nxt = count_q + CntW'(push) - CntW'(pop);
    count_d   = count_nxt;

    unique case (state_q)
      StIdle: begin
        if (count_q < Depth) state_d = StReq;
      end
      StReq: begin
        if (imem_gnt_i) begin
          pc_d     = pc_q + DATA_WIDTH'(4);
          req_pc_d = pc_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          // The response retires the outstanding transaction, so credits are just free slots.
          state_d   = (count_nxt < Depth) ? StReq : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      push       = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      flush_d    = 1'b1;
      misalign_d = |redirect_pc_i[1:0];
      discard_d  = 1'b0;
      unique case (state_q)
        StReq: begin
          // A grant this cycle leaves a transaction in flight whose data belongs to the old path.
          if (imem_gnt_i) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            state_d = StReq;
          end else begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      discard_q  <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && push) begin
      instr_mem_q[wptr_q] <= imem_rdata_i;
      pc_mem_q[wptr_q]    <= req_pc_q;
    end
  end

  always_comb begin
    imem_req_o    = (state_q == StReq);
    imem_addr_o   = pc_q;
    instr_valid_o = (count_q != '0);
    // Head is gated so decode never sees stale storage while the queue is empty.
    instr_o       = instr_valid_o ? instr_mem_q[rptr_q] : '0;
    instr_pc_o    = instr_valid_o ? pc_mem_q[rptr_q] : '0;
    flush_o       = flush_q;
    misalign_o    = misalign_q;
  end

endmodule

// File: tb/tb_core_fetch_unit.sv
// Directed bench for core_fetch_unit: a cycle-by-cycle vector table plus a streaming
// memory-model sequence checking order and one-per-two-cycle throughput.
module tb_core_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        flush_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  core_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  typedef struct {
    logic        rstn;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        flush;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rstn, input logic redir, input logic [31:0] rpc,
                   input logic gnt, input logic rvalid, input logic [31:0] rdata,
                   input logic ready, input logic req, input logic [31:0] addr,
                   input logic valid, input logic [31:0] instr, input logic [31:0] ipc,
                   input logic flush, input logic mis);
    vec_t e;
    e.rstn = rstn; e.redir = redir; e.rpc = rpc; e.gnt = gnt; e.rvalid = rvalid;
    e.rdata = rdata; e.ready = ready; e.req = req; e.addr = addr; e.valid = valid;
    e.instr = instr; e.ipc = ipc; e.flush = flush; e.mis = mis;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int first_cyc, last_cyc, got_n;
    logic        pending;
    logic [31:0] pend_addr, exp_pc;
    localparam logic [31:0] K = 32'hC0DE_0000;

    rstn_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;

    // Each row: inputs held across one rising edge, outputs expected after that edge.
    //  rstn redir rpc            gnt rv rdata         rdy  req addr          val instr          ipc           fl mis
    v(0, 0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0000,  1,   1, 32'h4,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h8,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0004,  1,   1, 32'h8,          1, 32'hA5A5_0004,  32'h4,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'hC,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0008,  1,   1, 32'hC,          1, 32'hA5A5_0008,  32'h8,          0, 0);
    // Backpressure: two entries fill the queue and fetch stalls.
    v(0, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h4,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0000,  0,   1, 32'h4,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h8,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0004,  0,   0, 32'h8,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h8,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h8,          1, 32'hA5A5_0004,  32'h4,          0, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h8,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'hC,          0, 32'h0,          32'h0,          0, 0);
    // Redirect while waiting: late response from 0x8 is dropped.
    v(1, 1, 32'h100,        0, 0, 32'h0,          1,   0, 32'h100,        0, 32'h0,          32'h0,          1, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0008,  1,   1, 32'h100,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h104,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0100,  1,   1, 32'h104,        1, 32'hA5A5_0100,  32'h100,        0, 0);
    // Misaligned redirect while requesting without grant.
    v(1, 1, 32'h102,        0, 0, 32'h0,          1,   1, 32'h100,        0, 32'h0,          32'h0,          1, 1);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h104,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0100,  0,   1, 32'h104,        1, 32'hA5A5_0100,  32'h100,        0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          0,   0, 32'h108,        1, 32'hA5A5_0100,  32'h100,        0, 0);
    // Redirect coinciding with rvalid and a pop.
    v(1, 1, 32'h200,        0, 1, 32'hA5A5_0104,  1,   1, 32'h200,        0, 32'h0,          32'h0,          1, 0);
    v(1, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h200,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h204,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0200,  1,   1, 32'h204,        1, 32'hA5A5_0200,  32'h200,        0, 0);
    // Reset mid-WAIT, then a stray rvalid.
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h208,        0, 32'h0,          32'h0,          0, 0);
    v(0, 0, 32'h0,          0, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  1,   1, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'hA5A5_0000,  1,   1, 32'h4,          1, 32'hA5A5_0000,  32'h0,          0, 0);
    // PC wrap.
    v(1, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC,  0, 32'h0,          32'h0,          1, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'h1234_5678,  1,   1, 32'h0,          1, 32'h1234_5678,  32'hFFFF_FFFC,  0, 0);
    // Redirect with grant in the same cycle: the in-flight response is discarded.
    v(1, 1, 32'h300,        1, 0, 32'h0,          1,   0, 32'h300,        0, 32'h0,          32'h0,          1, 0);
    v(1, 0, 32'h0,          0, 1, 32'h0000_0BAD,  1,   1, 32'h300,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          1, 0, 32'h0,          1,   0, 32'h304,        0, 32'h0,          32'h0,          0, 0);
    v(1, 0, 32'h0,          0, 1, 32'h0000_0300,  0,   1, 32'h304,        1, 32'h0000_0300,  32'h300,        0, 0);
    // Back-to-back redirects: the last one wins.
    v(1, 1, 32'h400,        0, 0, 32'h0,          0,   1, 32'h400,        0, 32'h0,          32'h0,          1, 0);
    v(1, 1, 32'h503,        0, 0, 32'h0,          0,   1, 32'h500,        0, 32'h0,          32'h0,          1, 1);
    v(1, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h500,        0, 32'h0,          32'h0,          0, 0);

    @(negedge clk_i);
    for (int i = 0; i < vecs.size(); i++) begin
      rstn_i = vecs[i].rstn; redirect_i = vecs[i].redir; redirect_pc_i = vecs[i].rpc;
      imem_gnt_i = vecs[i].gnt; imem_rvalid_i = vecs[i].rvalid;
      imem_rdata_i = vecs[i].rdata; instr_ready_i = vecs[i].ready;
      @(negedge clk_i);
      n_tests++;
      if (imem_req_o !== vecs[i].req || imem_addr_o !== vecs[i].addr ||
          instr_valid_o !== vecs[i].valid || instr_o !== vecs[i].instr ||
          instr_pc_o !== vecs[i].ipc || flush_o !== vecs[i].flush ||
          misalign_o !== vecs[i].mis) begin
        n_fail++;
        $display("FAIL row %0d: got req=%b addr=%h val=%b instr=%h pc=%h fl=%b mis=%b, expected req=%b addr=%h val=%b instr=%h pc=%h fl=%b mis=%b",
                 i, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, flush_o,
                 misalign_o, vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].instr,
                 vecs[i].ipc, vecs[i].flush, vecs[i].mis);
      end
    end

    // Streaming sequence: zero-wait memory, decode always ready.
    rstn_i = 1'b0; redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    pending = 1'b0; pend_addr = '0; exp_pc = '0; got_n = 0; first_cyc = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40 && got_n < 4; cyc++) begin
      @(negedge clk_i);
      if (instr_valid_o) begin
        check("stream_pc", instr_pc_o, exp_pc);
        check("stream_instr", instr_o, exp_pc ^ K);
        if (got_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        got_n++;
        exp_pc += 32'd4;
      end
      imem_rvalid_i = pending;
      imem_rdata_i  = pend_addr ^ K;
      imem_gnt_i    = imem_req_o;
      pending       = imem_req_o;
      if (imem_req_o) pend_addr = imem_addr_o;
    end
    check("stream_count", 32'(got_n), 32'd4);
    check("stream_spacing", 32'(last_cyc - first_cyc), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
